tftp_mode_decoder: RTL and testbench
====================================

// Module: tftp_mode_decoder
// PURPOSE
//  Multi-mode TFTP RRQ/WRQ mode-field decoder. Consumes the NUL-terminated mode string
//  one byte per en strobe, case-insensitively compares it against every supported mode
//  string in parallel, and reports a registered mode code plus done/valid/error flags.
//  Sits in the rx TFTP decoder after the filename parser and replaces single-hash checking.
// PARAMETERS
//  MAX_LEN  16                   max mode chars before NUL; one more non-NUL byte = overrun
//  LEN_W    $clog2(MAX_LEN+1)    width of byte counter / len output
//  FOLD_EN  1                    1: fold ASCII 'A'..'Z' to lowercase before compare; 0: exact
// PORTS
//  clk       in   1      clock
//  reset     in   1      synchronous, active-high; returns block to MATCH state
//  clear     in   1      per-packet restart; same effect as reset
//  en        in   1      eth_data holds a mode-field byte this cycle
//  eth_data  in   8      mode-field byte
//  done      out  1      NUL received; result fields stable until reset/clear
//  valid     out  1      done and exactly one mode matched
//  mode      out  2      0 NONE, 1 NETASCII, 2 OCTET, 3 MAIL
//  error     out  1      overrun: MAX_LEN+1 non-NUL bytes with no NUL
//  len       out  LEN_W  chars accepted before NUL (NUL excluded), saturates at MAX_LEN
// BEHAVIOUR
//  - Reset/clear values: done=0 valid=0 mode=0 error=0 len=0; state=MATCH; idx=0; all match_k=1.
//  - States: MATCH -> DONE (NUL) | ERROR (overrun). DONE, ERROR absorbing until reset/clear.
//  - MATCH, en=1, byte!=0: c=fold(byte); for each mode k (string S_k, length L_k):
//    match_k <= match_k & (idx<L_k) & (c==S_k[idx]); idx<=idx+1.
//  - MATCH, en=1, byte==0: state<=DONE; mode<=k where match_k & (idx==L_k), else 0;
//    valid<=(mode!=0); done<=1; len<=idx. Latency: flags high cycle after NUL byte.
//  - Overrun: en=1, byte!=0, idx==MAX_LEN -> state<=ERROR, error<=1, done=0, valid=0.
//  - en=0: no state change (gaps between bytes allowed, any length).
//  - en in DONE/ERROR ignored (trailing bytes never disturb result).
//  - clear/reset with en same cycle: clear wins, byte dropped, idx=0.
//  - Empty string (first byte NUL): done=1, valid=0, mode=0, len=0.
//  - Mode strings are prefix-distinct; at most one match_k true at NUL.
//  - fold(): 8'h41..8'h5A +8'h20 when FOLD_EN=1, else identity; other bytes unchanged.
// CONFIGURATION
//  TFTP_MODE_MAIL_EN defined: "mail" (L=4) matcher built; "MAIL\0" -> mode=3, valid=1.
//  Not defined: no mail matcher; "mail\0" -> done=1, valid=0, mode=0; code 3 never produced.
// STRUCTURE
//  Shared header tftp_defs.vh: TFTP_MODE_NONE/NETASCII/OCTET/MAIL codes (2 bits), mode
//  string constants and lengths ("netascii"=8, "octet"=5, "mail"=4).
//  Sub-module tftp_mode_match (params STR, STR_LEN): one per mode, holds match_k bit,
//  takes folded byte, idx, en, restart; outputs hit = match_k & (idx==STR_LEN).
//  Top holds fold, idx counter, FSM, output registers.
// TESTING
//  1 "octet\0" back-to-back en -> cycle after NUL: done=1 valid=1 mode=2 len=5 error=0.
//  2 "NetASCII\0" with en gaps of 3 cycles -> done=1 valid=1 mode=1 len=8.
//  3 "octets\0" and "oct\0" -> done=1 valid=0 mode=0, len=6 and 3.
//  4 17 bytes 'a' (MAX_LEN=16) -> error=1 cycle after 17th byte, done=0; later NUL ignored.
//  5 "MAIL\0": with TFTP_MODE_MAIL_EN mode=3 valid=1; without: valid=0 mode=0.
//  6 "oct" then clear (with en, byte 'e'), then "octet\0" -> mode=2 len=5; reset same.

Source files
------------

// File: rtl/tftp_mode_decoder_pkg.sv
// Shared definitions for the TFTP mode-field decoder.
//   mode_e          2-bit mode codes reported on the decoder's mode output
//   *_STR / *_LEN   supported mode strings (lowercase, first char in MSB byte)
//   fold_byte()     ASCII upper-to-lower fold used ahead of every matcher
package tftp_mode_decoder_pkg;

  typedef enum logic [1:0] {
    MODE_NONE     = 2'd0,
    MODE_NETASCII = 2'd1,
    MODE_OCTET    = 2'd2,
    MODE_MAIL     = 2'd3
  } mode_e;

  localparam int NETASCII_LEN = 8;
  localparam int OCTET_LEN    = 5;
  localparam int MAIL_LEN     = 4;

  localparam logic [8*NETASCII_LEN-1:0] NETASCII_STR = "netascii";
  localparam logic [8*OCTET_LEN-1:0]    OCTET_STR    = "octet";
  localparam logic [8*MAIL_LEN-1:0]     MAIL_STR     = "mail";

  function automatic logic [7:0] fold_byte(input logic [7:0] b, input logic fold_en);
    if (fold_en && (b >= 8'h41) && (b <= 8'h5A)) return b + 8'h20;
    return b;
  endfunction

endpackage

// File: rtl/tftp_mode_match.sv
// One mode-string matcher: tracks whether every byte seen so far agrees with STR.
//   clk, reset   clock / synchronous active-high reset
//   restart      per-packet restart (sets the match bit again)
//   step         a non-NUL byte is being accepted this cycle at position idx
//   char_in      folded byte
//   idx          position of char_in within the mode field
//   hit          all bytes matched and exactly STR_LEN of them have been seen
module tftp_mode_match
  import tftp_mode_decoder_pkg::*;
#(
  parameter int                     LEN_W   = 5,
  parameter int                     STR_LEN = OCTET_LEN,
  parameter logic [8*STR_LEN-1:0]   STR     = OCTET_STR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic             step,
  input  logic [7:0]       char_in,
  input  logic [LEN_W-1:0] idx,
  output logic             hit
);

  logic       match_q, match_d;
  logic [7:0] exp_char;
  logic       in_range;

  // Character select is a bounded loop so idx beyond STR_LEN never indexes out of STR.
  always_comb begin
    exp_char = 8'h00;
    in_range = 1'b0;
    for (int i = 0; i < STR_LEN; i++) begin
      if (idx == LEN_W'(i)) begin
        exp_char = STR[8*(STR_LEN-1-i) +: 8];
        in_range = 1'b1;
      end
    end
    match_d = match_q;
    if (restart)   match_d = 1'b1;
    else if (step) match_d = match_q & in_range & (char_in == exp_char);
  end

  always_ff @(posedge clk) begin
    if (reset) match_q <= 1'b1;
    else       match_q <= match_d;
  end

  assign hit = match_q & (idx == LEN_W'(STR_LEN));

endmodule

// File: rtl/tftp_mode_decoder.sv
// TFTP RRQ/WRQ mode-field decoder. Takes the NUL-terminated mode string one byte per
// en strobe, matches it case-insensitively against all supported modes in parallel and
// registers the result.
//   clk, reset        clock / synchronous active-high reset
//   clear             per-packet restart, same effect as reset, wins over en
//   en, eth_data      mode-field byte strobe and byte
//   done              NUL received; results stable until reset/clear
//   valid             done and a supported mode matched
//   mode              0 none, 1 netascii, 2 octet, 3 mail
//   error             more than MAX_LEN non-NUL bytes
//   len               characters before the NUL
// Build option: define TFTP_MODE_MAIL_EN to include the "mail" matcher.
//
// state   | meaning
// S_MATCH | accepting mode bytes
// S_DONE  | NUL seen, result held
// S_ERROR | overrun, result held
module tftp_mode_decoder
  import tftp_mode_decoder_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int FOLD_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [7:0]       eth_data,
  output logic             done,
  output logic             valid,
  output logic [1:0]       mode,
  output logic             error,
  output logic [LEN_W-1:0] len
);

  typedef enum logic [1:0] {S_MATCH, S_DONE, S_ERROR} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             done_q, done_d;
  logic             valid_q, valid_d;
  logic             error_q, error_d;
  mode_e            mode_q, mode_d;

  logic [7:0] char_c;
  logic       step;
  logic       hit_netascii, hit_octet, hit_mail;
  mode_e      nul_mode;

  assign char_c = fold_byte(eth_data, FOLD_EN != 0);

  tftp_mode_match #(.LEN_W(LEN_W), .STR_LEN(NETASCII_LEN), .STR(NETASCII_STR)) u_netascii (
    .clk(clk), .reset(reset), .restart(clear), .step(step),
    .char_in(char_c), .idx(idx_q), .hit(hit_netascii)
  );

  tftp_mode_match #(.LEN_W(LEN_W), .STR_LEN(OCTET_LEN), .STR(OCTET_STR)) u_octet (
    .clk(clk), .reset(reset), .restart(clear), .step(step),
    .char_in(char_c), .idx(idx_q), .hit(hit_octet)
  );

`ifdef TFTP_MODE_MAIL_EN
  tftp_mode_match #(.LEN_W(LEN_W), .STR_LEN(MAIL_LEN), .STR(MAIL_STR)) u_mail (
    .clk(clk), .reset(reset), .restart(clear), .step(step),
    .char_in(char_c), .idx(idx_q), .hit(hit_mail)
  );
`else
  assign hit_mail = 1'b0;
`endif

  // Strings are prefix-distinct, so at most one hit is ever set; order is arbitrary.
  always_comb begin
    nul_mode = MODE_NONE;
    if (hit_netascii)   nul_mode = MODE_NETASCII;
    else if (hit_octet) nul_mode = MODE_OCTET;
    else if (hit_mail)  nul_mode = MODE_MAIL;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    done_d  = done_q;
    valid_d = valid_q;
    error_d = error_q;
    mode_d  = mode_q;
    step    = 1'b0;
    if (clear) begin
      state_d = S_MATCH;
      idx_d   = '0;
      len_d   = '0;
      done_d  = 1'b0;
      valid_d = 1'b0;
      error_d = 1'b0;
      mode_d  = MODE_NONE;
    end else begin
      case (state_q)
        S_MATCH: begin
          if (en) begin
            if (eth_data == 8'h00) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              mode_d  = nul_mode;
              valid_d = (nul_mode != MODE_NONE);
              len_d   = idx_q;
            end else if (idx_q == LEN_W'(MAX_LEN)) begin
              state_d = S_ERROR;
              error_d = 1'b1;
            end else begin
              step  = 1'b1;
              idx_d = idx_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_MATCH;
      idx_q   <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      mode_q  <= MODE_NONE;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      error_q <= error_d;
      mode_q  <= mode_d;
    end
  end

  assign done  = done_q;
  assign valid = valid_q;
  assign mode  = mode_q;
  assign error = error_q;
  assign len   = len_q;

endmodule

// File: tb/tb_tftp_mode_decoder.sv
// Testbench for tftp_mode_decoder: directed cases plus randomized mode strings checked
// against a string-level reference model.
module tb_tftp_mode_decoder;

  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;

  logic             clk = 1'b0;
  logic             reset, clear, en;
  logic [7:0]       eth_data;
  logic             done, valid, error;
  logic [1:0]       mode;
  logic [LEN_W-1:0] len;

  int n_cmp = 0;
  int n_err = 0;

  tftp_mode_decoder dut (
    .clk(clk), .reset(reset), .clear(clear), .en(en), .eth_data(eth_data),
    .done(done), .valid(valid), .mode(mode), .error(error), .len(len)
  );

  always #5 clk = ~clk;

`ifdef TFTP_MODE_MAIL_EN
  localparam bit MAIL_ON = 1'b1;
`else
  localparam bit MAIL_ON = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input int ed, input int ev, input int em,
                           input int ee, input int el);
    chk({tag, ".done"},  {31'd0, done},  ed);
    chk({tag, ".valid"}, {31'd0, valid}, ev);
    chk({tag, ".mode"},  {30'd0, mode},  em);
    chk({tag, ".error"}, {31'd0, error}, ee);
    chk({tag, ".len"},   {27'd0, len},   el);
  endtask

  // All drive tasks start and end on a falling edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    en = 1'b1;
    eth_data = b;
    @(negedge clk);
    en = 1'b0;
    eth_data = 8'h00;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_str(input string s, input int gap, input bit nul);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
    if (nul) send_byte(8'h00, gap);
  endtask

  task automatic restart(input bit use_reset);
    if (use_reset) reset = 1'b1; else clear = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear = 1'b0;
  endtask

  // Reference: build the folded string, then compare whole strings.
  function automatic void model(input byte unsigned q[$], output int ed, output int ev,
                                output int em, output int ee, output int el,
                                output int used);
    string s = "";
    ed = 0; ev = 0; em = 0; ee = 0; el = 0; used = q.size();
    for (int i = 0; i < q.size(); i++) begin
      byte unsigned c = q[i];
      if (c == 0) begin
        ed = 1;
        el = s.len();
        if (s == "netascii")           em = 1;
        else if (s == "octet")         em = 2;
        else if (MAIL_ON && s == "mail") em = 3;
        ev = (em != 0);
        used = i + 1;
        return;
      end
      if (s.len() == MAX_LEN) begin
        ee = 1;
        used = i + 1;
        return;
      end
      if (c >= 8'h41 && c <= 8'h5A) c = c + 8'h20;
      s = $sformatf("%s%c", s, c);
    end
  endfunction

  initial begin
    string names[3];
    int ed, ev, em, ee, el, used;
    names[0] = "netascii"; names[1] = "octet"; names[2] = "mail";
    reset = 1'b1; clear = 1'b0; en = 1'b0; eth_data = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_all("reset", 0, 0, 0, 0, 0);

    send_str("octet", 0, 1'b1);
    check_all("octet", 1, 1, 2, 0, 5);
    send_str("netascii", 0, 1'b1);
    check_all("trailing", 1, 1, 2, 0, 5);
    restart(1'b0);

    send_str("NetASCII", 3, 1'b1);
    check_all("netascii_gap", 1, 1, 1, 0, 8);
    restart(1'b0);

    send_str("octets", 0, 1'b1);
    check_all("octets", 1, 0, 0, 0, 6);
    restart(1'b0);
    send_str("oct", 1, 1'b1);
    check_all("oct", 1, 0, 0, 0, 3);
    restart(1'b0);

    send_str("", 0, 1'b1);
    check_all("empty", 1, 0, 0, 0, 0);
    restart(1'b0);

    send_str("aaaaaaaaaaaaaaaa", 0, 1'b0);
    check_all("len16", 0, 0, 0, 0, 0);
    send_byte("a", 0);
    check_all("overrun", 0, 0, 0, 1, 0);
    send_byte(8'h00, 0);
    check_all("overrun_nul", 0, 0, 0, 1, 0);
    restart(1'b0);

    send_str("MAIL", 0, 1'b1);
    if (MAIL_ON) check_all("mail", 1, 1, 3, 0, 4);
    else         check_all("mail", 1, 0, 0, 0, 4);
    restart(1'b0);

    send_str("oct", 0, 1'b0);
    clear = 1'b1; en = 1'b1; eth_data = "e";
    @(negedge clk);
    clear = 1'b0; en = 1'b0; eth_data = 8'h00;
    send_str("octet", 0, 1'b1);
    check_all("clear_en", 1, 1, 2, 0, 5);

    send_str("oct", 0, 1'b0);
    reset = 1'b1; en = 1'b1; eth_data = "e";
    @(negedge clk);
    reset = 1'b0; en = 1'b0; eth_data = 8'h00;
    check_all("reset_en", 0, 0, 0, 0, 0);
    send_str("octet", 0, 1'b1);
    check_all("reset_octet", 1, 1, 2, 0, 5);
    restart(1'b1);

    for (int it = 0; it < 60; it++) begin
      byte unsigned q[$];
      int kind = $urandom_range(2);
      int gap  = $urandom_range(2);
      q = {};
      if (kind == 0 || kind == 1) begin
        string nm = names[$urandom_range(2)];
        int n = nm.len();
        if (kind == 1) n = $urandom_range(nm.len() + 1);
        for (int i = 0; i < n; i++) begin
          byte unsigned c = (i < nm.len()) ? nm[i] : "x";
          if ($urandom_range(1) == 1) c = c - 8'h20;
          q.push_back(c);
        end
      end else begin
        int n = $urandom_range(MAX_LEN + 3);
        for (int i = 0; i < n; i++) q.push_back(byte'($urandom_range(8'h41, 8'h7A)));
      end
      q.push_back(8'h00);
      q.push_back(8'h6F);
      model(q, ed, ev, em, ee, el, used);
      for (int i = 0; i < q.size(); i++) send_byte(q[i], gap);
      check_all($sformatf("rand%0d", it), ed, ev, em, ee, el);
      restart($urandom_range(1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
